// File: rtl/turtle_motion_pkg.sv
// Shared game constants, FSM encoding and width helpers for the turtle enemy.
package turtle_motion_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned SUM_W   = 12;

  localparam int unsigned SCREEN_X_MIN = 0;
  localparam int unsigned SCREEN_X_MAX = 1023;
  localparam int unsigned GROUND_Y     = 400;
  localparam int unsigned SPAWN_X      = 400;

  localparam int unsigned WALK_STEP_PX  = 1;
  localparam int unsigned SHELL_STEP_PX = 4;
  localparam int unsigned STOMP_TOL_PX  = 4;

  localparam int unsigned PRESS_COOLDOWN_FR = 8;
  localparam int unsigned TURN_TIMEOUT_FR   = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_MOVE      = 2'b01,
    ST_WAIT_TURN = 2'b10
  } state_e;

  // Zero-extend a screen coordinate so sums of two coordinates cannot wrap.
  function automatic logic [SUM_W-1:0] widen(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/turtle_motion_box_overlap.sv
// Combinational test whether two half-open intervals [pos, pos+len) intersect.
module box_overlap
  import turtle_motion_pkg::*;
(
  input  logic [COORD_W-1:0] a_pos_i,
  input  logic [COORD_W-1:0] a_len_i,
  input  logic [COORD_W-1:0] b_pos_i,
  input  logic [COORD_W-1:0] b_len_i,
  output logic               overlap_o
);

  logic [SUM_W-1:0] a_end;
  logic [SUM_W-1:0] b_end;

  assign a_end = widen(a_pos_i) + widen(a_len_i);
  assign b_end = widen(b_pos_i) + widen(b_len_i);

  // An empty interval never intersects anything.
  assign overlap_o = (a_len_i != '0) && (b_len_i != '0) &&
                     (widen(a_pos_i) < b_end) && (widen(b_pos_i) < a_end);

endmodule

// File: rtl/turtle_motion.sv
// Turtle enemy motion: walks/slides between the walls, bounces via the sprite
// block, and reports stomps (press_impulse) and side contact (hurt_mario).
module turtle_motion
  import turtle_motion_pkg::*;
#(
  parameter int unsigned X_INIT         = SPAWN_X,
  parameter int unsigned Y_GROUND       = GROUND_Y,
  parameter int unsigned X_MIN          = SCREEN_X_MIN,
  parameter int unsigned X_MAX          = SCREEN_X_MAX,
  parameter int unsigned WALK_STEP      = WALK_STEP_PX,
  parameter int unsigned SHELL_STEP     = SHELL_STEP_PX,
  parameter int unsigned STOMP_TOL      = STOMP_TOL_PX,
  parameter int unsigned PRESS_COOLDOWN = PRESS_COOLDOWN_FR,
  parameter int unsigned TURN_TIMEOUT   = TURN_TIMEOUT_FR
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               oriental,
  input  logic               shell,
  input  logic               shell_anim,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] mario_x,
  input  logic [COORD_W-1:0] mario_y,
  input  logic [COORD_W-1:0] mario_w,
  input  logic [COORD_W-1:0] mario_h,
  input  logic               mario_falling,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               collapsion_impulse,
  output logic               press_impulse,
  output logic               hurt_mario
);

  localparam int unsigned COOL_W = $clog2(PRESS_COOLDOWN + 1) > 0 ? $clog2(PRESS_COOLDOWN + 1) : 1;
  localparam int unsigned TURN_W = $clog2(TURN_TIMEOUT + 1) > 0 ? $clog2(TURN_TIMEOUT + 1) : 1;

  localparam logic [SUM_W-1:0]   X_MIN_S      = SUM_W'(X_MIN);
  localparam logic [SUM_W-1:0]   X_MAX_S      = SUM_W'(X_MAX);
  localparam logic [SUM_W-1:0]   WALK_STEP_S  = SUM_W'(WALK_STEP);
  localparam logic [SUM_W-1:0]   SHELL_STEP_S = SUM_W'(SHELL_STEP);
  localparam logic [SUM_W-1:0]   STOMP_TOL_S  = SUM_W'(STOMP_TOL);
  localparam logic [COORD_W-1:0] X_INIT_C     = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] X_MIN_C      = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C      = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_GROUND_C   = COORD_W'(Y_GROUND);
  localparam logic [COOL_W-1:0]  COOL_LOAD    = COOL_W'(PRESS_COOLDOWN);
  localparam logic [TURN_W-1:0]  TURN_LAST    = TURN_W'(TURN_TIMEOUT - 1);

  state_e              state_q;
  logic [COORD_W-1:0]  x_q;
  logic [COORD_W-1:0]  y_q;
  logic                coll_q;
  logic                press_q;
  logic                hurt_q;
  logic                ori_cap_q;
  logic [COOL_W-1:0]   cool_q;
  logic [TURN_W-1:0]   turn_cnt_q;

  logic [SUM_W-1:0]    step;
  logic                step_nz;
  logic [SUM_W-1:0]    right_edge;
  logic                wall_right;
  logic                wall_left;
  logic [COORD_W-1:0]  x_step_d;
  logic [SUM_W-1:0]    mario_bottom;
  logic                stomp_window;
  logic                x_ovl;
  logic                y_ovl;
  logic                can_collide;
  logic                stomp;
  logic                side_hit;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    step = '0;
    if (!shell)         step = WALK_STEP_S;
    else if (shell_anim) step = SHELL_STEP_S;
  end

  assign step_nz    = (step != '0);
  assign right_edge = widen(x_q) + widen(w) + step;
  assign wall_right = step_nz && !oriental && (right_edge > X_MAX_S);
  assign wall_left  = step_nz &&  oriental && (widen(x_q) < X_MIN_S + step);
  assign x_step_d   = oriental ? (x_q - step[COORD_W-1:0]) : (x_q + step[COORD_W-1:0]);

  box_overlap u_x_overlap (
    .a_pos_i   (mario_x),
    .a_len_i   (mario_w),
    .b_pos_i   (x_q),
    .b_len_i   (w),
    .overlap_o (x_ovl)
  );

  box_overlap u_y_overlap (
    .a_pos_i   (mario_y),
    .a_len_i   (mario_h),
    .b_pos_i   (y_q),
    .b_len_i   (h),
    .overlap_o (y_ovl)
  );

  // Stomp means Mario's feet land within STOMP_TOL pixels below the turtle's top.
  assign mario_bottom = widen(mario_y) + widen(mario_h);
  assign stomp_window = (mario_bottom >= widen(y_q)) && (mario_bottom <= widen(y_q) + STOMP_TOL_S);
  assign can_collide  = frame_tick && (cool_q == '0) &&
                        ((state_q == ST_MOVE) || (state_q == ST_WAIT_TURN));
  assign stomp        = can_collide && x_ovl && mario_falling && stomp_window;
  assign side_hit     = can_collide && x_ovl && y_ovl && !stomp && step_nz;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      x_q        <= X_INIT_C;
      y_q        <= Y_GROUND_C;
      coll_q     <= 1'b0;
      press_q    <= 1'b0;
      hurt_q     <= 1'b0;
      ori_cap_q  <= 1'b0;
      cool_q     <= '0;
      turn_cnt_q <= '0;
    end else if (!enable) begin
      state_q    <= ST_IDLE;
      x_q        <= X_INIT_C;
      hurt_q     <= 1'b0;
      cool_q     <= '0;
      turn_cnt_q <= '0;
    end else begin
      y_q    <= Y_GROUND_C - h;
      hurt_q <= side_hit;

      if (stomp) begin
        press_q <= ~press_q;
        cool_q  <= COOL_LOAD;
      end else if (frame_tick && (cool_q != '0)) begin
        cool_q <= cool_q - COOL_W'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          x_q     <= X_INIT_C;
          state_q <= ST_MOVE;
        end
        ST_MOVE: begin
          if (frame_tick) begin
            if (wall_right || wall_left) begin
              x_q        <= wall_right ? (X_MAX_C - w) : X_MIN_C;
              coll_q     <= ~coll_q;
              ori_cap_q  <= oriental;
              turn_cnt_q <= '0;
              state_q    <= ST_WAIT_TURN;
            end else begin
              x_q <= x_step_d;
            end
          end
        end
        ST_WAIT_TURN: begin
          // The sprite block flips oriental in response to the impulse; give up after a timeout.
          if (oriental != ori_cap_q) begin
            state_q <= ST_MOVE;
          end else if (frame_tick) begin
            if (turn_cnt_q == TURN_LAST) begin
              turn_cnt_q <= '0;
              state_q    <= ST_MOVE;
            end else begin
              turn_cnt_q <= turn_cnt_q + TURN_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x                  = x_q;
  assign y                  = y_q;
  assign collapsion_impulse = coll_q;
  assign press_impulse      = press_q;
  assign hurt_mario         = hurt_q;

endmodule

// File: tb/tb_turtle_motion.sv
// Self-checking bench for turtle_motion: directed scenarios plus random traffic,
// all compared each cycle against a frame-level behavioural model.
module tb_turtle_motion;

  localparam int X_INIT = 400, Y_GROUND = 400, X_MIN = 0, X_MAX = 1023;
  localparam int WALK_STEP = 1, SHELL_STEP = 4, STOMP_TOL = 4;
  localparam int PRESS_COOLDOWN = 8, TURN_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rstn, frame_tick, enable, oriental, shell, shell_anim, mario_falling;
  logic [10:0] w, h, mario_x, mario_y, mario_w, mario_h;
  logic [10:0] x, y;
  logic        collapsion_impulse, press_impulse, hurt_mario;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_x, m_y, m_cool, m_turn_ticks;
  bit m_active, m_turning, m_cap, m_coll, m_press, m_hurt;

  always #5 clk = ~clk;

  turtle_motion #(
    .X_INIT(X_INIT), .Y_GROUND(Y_GROUND), .X_MIN(X_MIN), .X_MAX(X_MAX),
    .WALK_STEP(WALK_STEP), .SHELL_STEP(SHELL_STEP), .STOMP_TOL(STOMP_TOL),
    .PRESS_COOLDOWN(PRESS_COOLDOWN), .TURN_TIMEOUT(TURN_TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .enable(enable),
    .oriental(oriental), .shell(shell), .shell_anim(shell_anim),
    .w(w), .h(h), .mario_x(mario_x), .mario_y(mario_y),
    .mario_w(mario_w), .mario_h(mario_h), .mario_falling(mario_falling),
    .x(x), .y(y), .collapsion_impulse(collapsion_impulse),
    .press_impulse(press_impulse), .hurt_mario(hurt_mario)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit spans_meet(input int a, input int al, input int b, input int bl);
    return (al > 0) && (bl > 0) && (a < b + bl) && (b < a + al);
  endfunction

  task automatic model_reset();
    m_x = X_INIT; m_y = Y_GROUND; m_cool = 0; m_turn_ticks = 0;
    m_active = 0; m_turning = 0; m_cap = 0; m_coll = 0; m_press = 0; m_hurt = 0;
  endtask

  // One clock of the turtle's rules, evaluated on the inputs present at the edge.
  task automatic model_clock();
    int step, nx, ncool, nturn, feet;
    bit nact, nturning, ncap, ncoll, npress, nhurt, xo, yo, stomp;
    if (!enable) begin
      m_active = 0; m_turning = 0; m_cool = 0; m_turn_ticks = 0;
      m_x = X_INIT; m_hurt = 0;
      return;
    end
    step = shell ? (shell_anim ? SHELL_STEP : 0) : WALK_STEP;
    nx = m_x; ncool = m_cool; nturn = m_turn_ticks;
    nact = m_active; nturning = m_turning; ncap = m_cap;
    ncoll = m_coll; npress = m_press; nhurt = 0;

    if (m_active && frame_tick && m_cool == 0) begin
      xo = spans_meet(int'(mario_x), int'(mario_w), m_x, int'(w));
      yo = spans_meet(int'(mario_y), int'(mario_h), m_y, int'(h));
      feet = int'(mario_y) + int'(mario_h);
      stomp = xo && mario_falling && (feet >= m_y) && (feet <= m_y + STOMP_TOL);
      if (stomp) begin
        npress = !m_press;
        ncool = PRESS_COOLDOWN;
      end else if (xo && yo && step != 0) begin
        nhurt = 1;
      end
    end
    if (frame_tick && m_cool > 0) ncool = m_cool - 1;

    if (!m_active) begin
      nact = 1; nx = X_INIT;
    end else if (!m_turning) begin
      if (frame_tick && step != 0) begin
        if (!oriental && (m_x + int'(w) + step > X_MAX)) begin
          nx = X_MAX - int'(w); ncoll = !m_coll; ncap = oriental; nturning = 1; nturn = 0;
        end else if (oriental && (m_x < X_MIN + step)) begin
          nx = X_MIN; ncoll = !m_coll; ncap = oriental; nturning = 1; nturn = 0;
        end else begin
          nx = oriental ? m_x - step : m_x + step;
        end
      end
    end else begin
      if (oriental != m_cap) nturning = 0;
      else if (frame_tick) begin
        nturn = m_turn_ticks + 1;
        if (nturn >= TURN_TIMEOUT) begin nturning = 0; nturn = 0; end
      end
    end

    m_x = nx; m_cool = ncool; m_turn_ticks = nturn; m_active = nact;
    m_turning = nturning; m_cap = ncap; m_coll = ncoll; m_press = npress; m_hurt = nhurt;
    m_y = (Y_GROUND - int'(h)) & 'h7ff;
  endtask

  task automatic compare_all();
    check("x", 32'(x), m_x);
    check("y", 32'(y), m_y);
    check("collapsion_impulse", 32'(collapsion_impulse), 32'(m_coll));
    check("press_impulse", 32'(press_impulse), 32'(m_press));
    check("hurt_mario", 32'(hurt_mario), 32'(m_hurt));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rstn) model_clock();
    else model_reset();
    #1 compare_all();
  endtask

  task automatic tick();
    frame_tick = 1'b1; cycle();
    frame_tick = 1'b0; cycle();
  endtask

  task automatic mario_far();
    mario_x = 11'd2000; mario_y = 11'd0; mario_w = 11'd16; mario_h = 11'd16; mario_falling = 1'b0;
  endtask

  task automatic restart_turtle();
    enable = 1'b0; cycle();
    enable = 1'b1; cycle();
  endtask

  initial begin
    bit prev_coll, p0, c0;
    int mx;
    rstn = 1'b0; frame_tick = 1'b0; enable = 1'b0; oriental = 1'b0;
    shell = 1'b0; shell_anim = 1'b0; w = 11'd16; h = 11'd16;
    mario_far();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", 32'(x), X_INIT);
    check("reset_y", 32'(y), Y_GROUND);
    check("reset_coll", 32'(collapsion_impulse), 0);
    check("reset_press", 32'(press_impulse), 0);
    check("reset_hurt", 32'(hurt_mario), 0);
    rstn = 1'b1;

    // Walk right into the wall
    enable = 1'b1; cycle();
    for (int i = 0; i < 700 && !m_coll; i++) tick();
    check("wall_reached", 32'(m_coll), 1);
    check("wall_x", 32'(x), X_MAX - 16);
    check("wall_coll", 32'(collapsion_impulse), 1);
    cycle(); cycle();
    oriental = 1'b1; cycle();
    tick();
    check("turn_back_x", 32'(x), X_MAX - 17);

    // Turn timeout: hit the wall again and leave oriental unchanged
    oriental = 1'b0;
    tick(); tick();
    check("timeout_hit_x", 32'(x), X_MAX - 16);
    check("timeout_hit_coll", 32'(collapsion_impulse), 0);
    repeat (TURN_TIMEOUT) tick();
    check("timeout_no_retoggle", 32'(collapsion_impulse), 0);
    tick();
    check("timeout_rehit_coll", 32'(collapsion_impulse), 1);

    // Stomp on a stationary shell, then cooldown
    shell = 1'b1; shell_anim = 1'b0;
    restart_turtle();
    check("stomp_setup_x", 32'(x), X_INIT);
    check("stomp_setup_y", 32'(y), Y_GROUND - 16);
    mario_x = 11'd400; mario_y = 11'd368; mario_falling = 1'b1;
    p0 = m_press;
    tick();
    check("stomp_toggle", 32'(press_impulse), 32'(!p0));
    for (int i = 0; i < PRESS_COOLDOWN; i++) begin
      tick();
      check("stomp_cooldown", 32'(press_impulse), 32'(!p0));
    end
    tick();
    check("stomp_after_cooldown", 32'(press_impulse), 32'(p0));

    // Side contact while walking, none from a stationary shell
    mario_far();
    shell = 1'b0; oriental = 1'b1;
    restart_turtle();
    mario_x = 11'd410; mario_y = 11'd384; mario_falling = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1; cycle();
      check("hurt_pulse", 32'(hurt_mario), 1);
      frame_tick = 1'b0; cycle();
      check("hurt_one_cycle", 32'(hurt_mario), 0);
    end
    shell = 1'b1; shell_anim = 1'b0;
    frame_tick = 1'b1; cycle();
    check("hurt_still_shell", 32'(hurt_mario), 0);
    frame_tick = 1'b0; cycle();

    // Shell slide into the left wall
    mario_far();
    shell = 1'b0; oriental = 1'b1;
    restart_turtle();
    tick(); tick();
    shell = 1'b1; shell_anim = 1'b1;
    repeat (98) tick();
    check("slide_x6", 32'(x), 6);
    tick();
    check("slide_x2", 32'(x), 2);
    c0 = m_coll;
    tick();
    check("slide_clamp_x", 32'(x), X_MIN);
    check("slide_clamp_coll", 32'(collapsion_impulse), 32'(!c0));

    // Reset mid-slide, then stay disabled
    oriental = 1'b0; cycle();
    tick(); tick();
    #3 rstn = 1'b0;
    #1;
    check("async_reset_x", 32'(x), X_INIT);
    check("async_reset_y", 32'(y), Y_GROUND);
    check("async_reset_coll", 32'(collapsion_impulse), 0);
    check("async_reset_press", 32'(press_impulse), 0);
    model_reset();
    enable = 1'b0;
    cycle();
    rstn = 1'b1;
    repeat (10) tick();
    check("disabled_x", 32'(x), X_INIT);
    check("disabled_coll", 32'(collapsion_impulse), 0);
    check("disabled_press", 32'(press_impulse), 0);

    // Random traffic against the model
    enable = 1'b1;
    prev_coll = m_coll;
    for (int i = 0; i < 4000; i++) begin
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 999) < 5) begin
        rstn = 1'b0;
        model_reset();
      end
      enable     = ($urandom_range(0, 99) < 97);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) < 5) shell = !shell;
      if ($urandom_range(0, 99) < 5) shell_anim = !shell_anim;
      if (m_coll != prev_coll && $urandom_range(0, 9) < 7) oriental = !oriental;
      else if ($urandom_range(0, 99) < 2) oriental = !oriental;
      prev_coll = m_coll;
      if ($urandom_range(0, 99) < 2) w = ($urandom_range(0, 1) != 0) ? 11'd16 : 11'd24;
      if ($urandom_range(0, 99) < 2) h = ($urandom_range(0, 1) != 0) ? 11'd16 : 11'd24;
      mx = m_x + $urandom_range(0, 40) - 20;
      mario_x = (mx < 0) ? 11'd0 : 11'(mx);
      mario_y = 11'(m_y + $urandom_range(0, 32) - 24);
      mario_w = 11'd16; mario_h = 11'd16;
      mario_falling = $urandom_range(0, 1) != 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
